// File: rtl/uartrx_fifo.sv
// Purpose : UART receiver (8N1, LSB first) feeding a circular byte FIFO, with go/data/data_ready handoff.
// Latency : a byte is pushed at the stop-bit sample and presented (data_ready) on the following cycle.
// Backpr. : consumer paces pops via go; a byte arriving into a full FIFO is dropped and flags overrun.
module uartrx_fifo #(
    parameter int ClockFrequencyHz  = 30_000_000,
    parameter int BaudRate          = 115200,
    parameter int FifoDepthBitWidth = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx,
    input  logic                         go,
    output logic [7:0]                   data,
    output logic                         data_ready,
    output logic [FifoDepthBitWidth:0]   fifo_count,
    output logic                         overrun,
    output logic                         framing_error,
    input  logic                         clear_errors
);

    localparam int BitCycles     = ClockFrequencyHz / BaudRate;
    localparam int HalfBitCycles = BitCycles / 2;
    localparam int CntW          = (BitCycles > 1) ? $clog2(BitCycles) : 1;
    localparam int Depth         = 1 << FifoDepthBitWidth;
    localparam int AW            = FifoDepthBitWidth;

    localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBitCycles - 1);
    localparam logic [AW:0]     FullCnt  = (AW + 1)'(Depth);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // rx synchronizer and receiver state
    logic            rx_meta_q, rx_sync_q;
    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push, frame_bad;

    // FIFO and handshake state
    logic [7:0]      mem [Depth];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW:0]     count_q;
    logic            delivered_q;
    logic            overrun_q, ferr_q;
    logic            pop, full, push_ok, ovr_set;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next state: half-bit start check, then one sample per bit period
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    push      = rx_sync_q;
                    frame_bad = !rx_sync_q;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop frees a slot on the same edge, so a full FIFO can still accept a push then
    assign full    = (count_q == FullCnt);
    assign pop     = delivered_q && !go;
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    // Storage array carries no reset; empty-gating on data hides stale contents
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // Pointers, count, delivery tracking and sticky flags (set beats clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            delivered_q <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (pop) begin
                delivered_q <= 1'b0;
            end else if (go && data_ready) begin
                delivered_q <= 1'b1;
            end
            overrun_q <= (overrun_q && !clear_errors) || ovr_set;
            ferr_q    <= (ferr_q && !clear_errors) || frame_bad;
        end
    end

    assign data          = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;
    assign data_ready    = go && (count_q != '0);
    assign fifo_count    = count_q;
    assign overrun       = overrun_q;
    assign framing_error = ferr_q;

endmodule
